// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the main-memory port.
//   req/we         per-requester request level and write enable (bit n = requester n)
//   addr0/addr1    requester addresses
//   wdata0/wdata1  requester write data
//   grant/ack/err  one-hot owner, one-cycle completion pulse, timeout flag (valid with ack)
//   rdata          read data returned to the owner, valid with ack
//   mem_*          single memory port: valid/we/addr/wdata out, ready/rdata back
// Modport slave is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        grant;
    logic [1:0]        ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_ready, mem_rdata,
        output grant, ack, err, rdata, mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_ready, mem_rdata,
        input  grant, ack, err, rdata, mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the single main-memory port.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_bus_arbiter_if.slave: requester side (req/we/addr/wdata in,
//          grant/ack/err/rdata out) and memory side (mem_* out, mem_ready/mem_rdata in)
// The winner owns the memory port for the whole transaction; a watchdog
// aborts with err=1 if mem_ready has not arrived after TIMEOUT BUSY cycles.
//
// state | meaning
// IDLE  | no owner; pick a winner from req and latch its command
// BUSY  | mem_valid high, command held, waiting on mem_ready or timeout
// DONE  | one-cycle ack to the owner, owner recorded for round-robin
module mem_bus_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int TIMER_W = $clog2(TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q,     state_nxt;
    logic [1:0]        grant_q,     grant_nxt;
    logic [1:0]        ack_q,       ack_nxt;
    logic              err_q,       err_nxt;
    logic [DATA_W-1:0] rdata_q,     rdata_nxt;
    logic              mem_valid_q, mem_valid_nxt;
    logic              mem_we_q,    mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic              last_q,      last_nxt;
    logic [TIMER_W-1:0] timer_q,    timer_nxt;
    logic              pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_q      <= 1'b1;
            timer_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            grant_q     <= grant_nxt;
            ack_q       <= ack_nxt;
            err_q       <= err_nxt;
            rdata_q     <= rdata_nxt;
            mem_valid_q <= mem_valid_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            last_q      <= last_nxt;
            timer_q     <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        grant_nxt     = grant_q;
        ack_nxt       = '0;
        err_nxt       = err_q;
        rdata_nxt     = rdata_q;
        mem_valid_nxt = mem_valid_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        last_nxt      = last_q;
        timer_nxt     = timer_q;
        pick1         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    // On a tie the requester that did not own the port last wins.
                    if (bus.req == 2'b11) pick1 = ~last_q;
                    else                  pick1 = bus.req[1];
                    grant_nxt     = pick1 ? 2'b10 : 2'b01;
                    mem_we_nxt    = pick1 ? bus.we[1] : bus.we[0];
                    mem_addr_nxt  = pick1 ? bus.addr1 : bus.addr0;
                    mem_wdata_nxt = pick1 ? bus.wdata1 : bus.wdata0;
                    mem_valid_nxt = 1'b1;
                    timer_nxt     = '0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                // A late mem_ready in the final watchdog cycle still completes normally.
                if (bus.mem_ready) begin
                    if (!mem_we_q) rdata_nxt = bus.mem_rdata;
                    err_nxt       = 1'b0;
                    mem_valid_nxt = 1'b0;
                    ack_nxt       = grant_q;
                    state_nxt     = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    err_nxt       = 1'b1;
                    rdata_nxt     = '0;
                    mem_valid_nxt = 1'b0;
                    ack_nxt       = grant_q;
                    state_nxt     = DONE;
                end else begin
                    timer_nxt = timer_q + TIMER_W'(1);
                end
            end
            DONE: begin
                last_nxt  = grant_q[1];
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mem_bus_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

    mem_bus_arbiter #(.ADDR_W(15), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        tests = 0;
        fails = 0;

        // Reset held with both requesting; memory answers instantly throughout contention.
        rst_n         = 1'b0;
        bus.req       = 2'b11;
        bus.we        = 2'b00;
        bus.addr0     = 15'h0AAA;
        bus.addr1     = 15'h0555;
        bus.wdata0    = 16'h0000;
        bus.wdata1    = 16'h0000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        tick();
        tick();
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        chk("rst_ack", bus.ack, 2'b00);
        chk("rst_rdata", bus.rdata, 16'h0000);
        chk("rst_mem_addr", bus.mem_addr, 15'h0000);
        rst_n = 1'b1;

        // Contention: 01,10,01,10 with 3-cycle spacing.
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("rr_grant", bus.grant, exp_g);
            chk("rr_mem_valid", bus.mem_valid, 1'b1);
            chk("rr_mem_addr", bus.mem_addr, (r % 2 == 0) ? 15'h0AAA : 15'h0555);
            tick();
            chk("rr_ack", bus.ack, exp_g);
            chk("rr_rdata", bus.rdata, 16'h5A5A);
            chk("rr_mem_valid_done", bus.mem_valid, 1'b0);
            if (r == 3) begin
                bus.req       = 2'b00;
                bus.mem_ready = 1'b0;
            end
            tick();
            chk("rr_idle_grant", bus.grant, 2'b00);
            chk("rr_idle_ack", bus.ack, 2'b00);
        end
        tick();
        chk("idle_hold_grant", bus.grant, 2'b00);
        chk("idle_hold_valid", bus.mem_valid, 1'b0);

        // Single read, ready in the last watchdog cycle; requester address changes are ignored.
        bus.we    = 2'b00;
        bus.addr0 = 15'h0123;
        bus.req   = 2'b01;
        tick();
        chk("rd_grant", bus.grant, 2'b01);
        chk("rd_mem_valid", bus.mem_valid, 1'b1);
        chk("rd_mem_addr", bus.mem_addr, 15'h0123);
        chk("rd_mem_we", bus.mem_we, 1'b0);
        bus.addr0 = 15'h0456;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_busy_valid", bus.mem_valid, 1'b1);
            chk("rd_busy_addr", bus.mem_addr, 15'h0123);
            chk("rd_busy_ack", bus.ack, 2'b00);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        chk("rd_ack", bus.ack, 2'b01);
        chk("rd_rdata", bus.rdata, 16'hBEEF);
        chk("rd_err", bus.err, 1'b0);
        chk("rd_valid_drop", bus.mem_valid, 1'b0);
        bus.req       = 2'b00;
        bus.mem_ready = 1'b0;
        tick();
        chk("rd_idle_ack", bus.ack, 2'b00);
        chk("rd_idle_grant", bus.grant, 2'b00);

        // Single write with immediate ready; rdata must keep the previous read value.
        bus.req       = 2'b10;
        bus.we        = 2'b10;
        bus.addr1     = 15'h7FFF;
        bus.wdata1    = 16'h1234;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        chk("wr_grant", bus.grant, 2'b10);
        chk("wr_mem_we", bus.mem_we, 1'b1);
        chk("wr_mem_addr", bus.mem_addr, 15'h7FFF);
        chk("wr_mem_wdata", bus.mem_wdata, 16'h1234);
        tick();
        chk("wr_ack", bus.ack, 2'b10);
        chk("wr_rdata_kept", bus.rdata, 16'hBEEF);
        chk("wr_err", bus.err, 1'b0);
        bus.req       = 2'b00;
        bus.we        = 2'b00;
        bus.mem_ready = 1'b0;
        tick();
        chk("wr_idle_ack", bus.ack, 2'b00);

        // Timeout: owner drops req right after grant, memory never answers.
        bus.req       = 2'b01;
        bus.addr0     = 15'h0111;
        bus.mem_rdata = 16'hFFFF;
        tick();
        chk("to_grant", bus.grant, 2'b01);
        chk("to_valid_0", bus.mem_valid, 1'b1);
        bus.req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_valid_n", bus.mem_valid, 1'b1);
            chk("to_no_ack", bus.ack, 2'b00);
        end
        tick();
        chk("to_valid_drop", bus.mem_valid, 1'b0);
        chk("to_ack", bus.ack, 2'b01);
        chk("to_err", bus.err, 1'b1);
        chk("to_rdata", bus.rdata, 16'h0000);
        tick();
        chk("to_idle_ack", bus.ack, 2'b00);

        // Requester 1 read after the abort is served normally.
        bus.req   = 2'b10;
        bus.addr1 = 15'h0042;
        tick();
        chk("post_grant", bus.grant, 2'b10);
        chk("post_mem_addr", bus.mem_addr, 15'h0042);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1357;
        tick();
        chk("post_ack", bus.ack, 2'b10);
        chk("post_err", bus.err, 1'b0);
        chk("post_rdata", bus.rdata, 16'h1357);
        bus.req       = 2'b00;
        bus.mem_ready = 1'b0;
        tick();

        // Reset in the middle of BUSY.
        bus.req   = 2'b01;
        bus.addr0 = 15'h0222;
        tick();
        chk("mr_valid", bus.mem_valid, 1'b1);
        bus.req = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid_async", bus.mem_valid, 1'b0);
        chk("mr_grant_async", bus.grant, 2'b00);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        chk("mr_no_ack0", bus.ack, 2'b00);
        chk("mr_valid_idle", bus.mem_valid, 1'b0);
        tick();
        chk("mr_no_ack1", bus.ack, 2'b00);
        chk("mr_rdata", bus.rdata, 16'h0000);
        bus.req = 2'b01;
        tick();
        chk("mr_regrant", bus.grant, 2'b01);
        chk("mr_regrant_addr", bus.mem_addr, 15'h0222);
        bus.req = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-port round-robin arbiter that shares the single main-memory port between two requesters, e.g. the CPU-side cache and a second master such as an instruction cache or DMA. It holds the winning request for the full memory transaction and returns read data with a one-cycle ack. A watchdog aborts transactions the memory never answers.

Parameters:
ADDR_W, 15, address width of requester and memory ports
DATA_W, 16, data width of requester and memory ports
TIMEOUT, 64, max cycles waiting for mem_ready before abort (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  2  per-requester request, level, held until ack
we  in  2  per-requester write enable (1=write, 0=read)
addr0  in  ADDR_W  requester 0 address
addr1  in  ADDR_W  requester 1 address
wdata0  in  DATA_W  requester 0 write data
wdata1  in  DATA_W  requester 1 write data
grant  out  2  one-hot current owner, 0 when idle
ack  out  2  one-cycle completion pulse to owner
err  out  1  valid with ack; 1 = timeout abort
rdata  out  DATA_W  read data, valid with ack
mem_valid  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion, one cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n=0.
- Reset values: state=IDLE, grant=0, ack=0, err=0, rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, last=1 (requester 0 wins first tie), timer=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if req!=0, choose winner. A single request wins. If both request, the requester not equal to last wins. Latch winner's we/addr/wdata into the mem_* registers, set grant one-hot, clear timer, go BUSY. If req=0, stay in IDLE.
- BUSY: mem_valid=1 with the latched fields held stable. Requester inputs are ignored, so changes on addr/wdata do not propagate.
  - If mem_ready=1: capture mem_rdata into rdata when mem_we=0 (rdata unchanged on writes), err=0, go DONE.
  - Else if timer==TIMEOUT-1: err=1, rdata=0, go DONE.
  - Else timer+1.
- DONE: ack[owner]=1 for exactly one cycle, mem_valid=0, last=owner. Go IDLE with grant cleared.
- Minimum latency: req sampled at edge 0, mem_valid high after edge 1. If mem_ready is high that cycle, ack is high after edge 2. Back-to-back grants occur every 3 cycles minimum.
- Requesters deassert req in the cycle after ack. A req still high in IDLE is a new request, and round-robin then favours the other requester if it is waiting.
- mem_ready while not in BUSY is ignored.
- A requester dropping req while it is owner does not abort the transaction; the ack is still issued.
- rst_n asserted mid-transaction: mem_valid drops asynchronously, no ack is issued, and the transaction is lost.
- Timer is log2(TIMEOUT)+1 bits wide, saturates at TIMEOUT-1, and does not wrap.

Test Plan:
- Reset: hold rst_n=0 with req=2'b11 → grant=0, mem_valid=0, ack=0. Release → requester 0 granted first (last=1).
- Single read: req0, we0=0, addr0=0x0123, mem_ready after 3 BUSY cycles with mem_rdata=0xBEEF → mem_addr=0x0123, mem_we=0, then ack=2'b01, rdata=0xBEEF, err=0.
- Single write: req1, we1=1, addr1=0x7FFF, wdata1=0x1234, immediate mem_ready → mem_wdata=0x1234, mem_we=1, ack=2'b10 two edges after req, rdata unchanged.
- Contention: req=2'b11 continuously, memory answers in 1 cycle → grants alternate 01,10,01,10; each ack lands on the matching bit; 3-cycle spacing.
- Timeout: req0 read, mem_ready never asserted, TIMEOUT=4 → mem_valid high for exactly 4 cycles, then ack=2'b01, err=1, rdata=0. A following req1 is served normally.
- Reset mid-BUSY: assert rst_n=0 during BUSY → mem_valid falls without a clock edge. After release, no ack has been seen and state is IDLE.
